// File: rtl/pulse_sched.sv
// Radar pulse scheduler: steps through a stagger table of (pw, pri, rep) entries,
// emitting rep+1 PRIs per entry with a pulse of pw clocks at the head of each PRI.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   cfg_we/addr/pw/pri/rep  table write port (accepted only outside RUN)
//   num_entries, loop_en    dwell length (sampled at start) and wrap control
//   start, abort            dwell control
//   pulse_out, pri_strobe   pulse and PRI-start marker
//   pw_out, pri_out, entry_idx  active entry parameters and index
//   busy, done              RUN indicator and one-cycle completion pulse
module pulse_sched #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW_W  = 4,
  parameter int unsigned PRI_W = 8,
  parameter int unsigned REP_W = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_we,
  input  logic [$clog2(DEPTH)-1:0]          cfg_addr,
  input  logic [PW_W-1:0]                   cfg_pw,
  input  logic [PRI_W-1:0]                  cfg_pri,
  input  logic [REP_W-1:0]                  cfg_rep,
  input  logic [$clog2(DEPTH):0]            num_entries,
  input  logic                              loop_en,
  input  logic                              start,
  input  logic                              abort,
  output logic                              pulse_out,
  output logic                              pri_strobe,
  output logic [PW_W-1:0]                   pw_out,
  output logic [PRI_W-1:0]                  pri_out,
  output logic [$clog2(DEPTH)-1:0]          entry_idx,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PRI_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [NW-1:0]    n_q, n_d;
  logic [PW_W-1:0]  pw_q, pw_d;
  logic [PRI_W-1:0] pri_q, pri_d;
  logic             pulse_q, pulse_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             run_d;
  logic             tab_we_c;
  logic             last_entry_c;
  logic [AW-1:0]    nxt_idx_c;
  logic [NW-1:0]    n_clamp_c;

  logic [PW_W-1:0]  pw_tab_q  [DEPTH];
  logic [PRI_W-1:0] pri_tab_q [DEPTH];
  logic [REP_W-1:0] rep_tab_q [DEPTH];

  // Stagger table storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pw_tab_q[i]  <= '0;
        pri_tab_q[i] <= '0;
        rep_tab_q[i] <= '0;
      end
    end else if (tab_we_c) begin
      pw_tab_q[cfg_addr]  <= cfg_pw;
      pri_tab_q[cfg_addr] <= cfg_pri;
      rep_tab_q[cfg_addr] <= cfg_rep;
    end
  end

  assign nxt_idx_c    = idx_q + AW'(1);
  assign last_entry_c = (NW'(idx_q) + NW'(1)) >= n_q;
  assign n_clamp_c    = (num_entries > NW'(DEPTH)) ? NW'(DEPTH) : num_entries;

  // Next-state and next-output logic; outputs are registered from the *_d values
  // so pulse_out/pri_strobe track the state/counter that take effect at the same edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    idx_d    = idx_q;
    n_d      = n_q;
    pw_d     = pw_q;
    pri_d    = pri_q;
    tab_we_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        tab_we_c = cfg_we;
        if (start && (num_entries != '0)) begin
          state_d = S_RUN;
          n_d     = n_clamp_c;
          idx_d   = '0;
          cnt_d   = '0;
          rep_d   = '0;
          pw_d    = pw_tab_q[0];
          pri_d   = pri_tab_q[0];
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rep_d   = '0;
        end else if (cnt_q >= pri_q) begin
          cnt_d = '0;
          if (rep_q < rep_tab_q[idx_q]) begin
            rep_d = rep_q + REP_W'(1);
          end else if (!last_entry_c) begin
            idx_d = nxt_idx_c;
            rep_d = '0;
            pw_d  = pw_tab_q[nxt_idx_c];
            pri_d = pri_tab_q[nxt_idx_c];
          end else if (loop_en) begin
            idx_d = '0;
            rep_d = '0;
            pw_d  = pw_tab_q[0];
            pri_d = pri_tab_q[0];
          end else begin
            state_d = S_DONE;
            rep_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + PRI_W'(1);
        end
      end
      S_DONE: begin
        tab_we_c = cfg_we;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    run_d    = (state_d == S_RUN);
    pulse_d  = run_d && (32'(cnt_d) < 32'(pw_d));
    strobe_d = run_d && (cnt_d == '0);
    busy_d   = run_d;
    done_d   = (state_d == S_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rep_q    <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      pw_q     <= '0;
      pri_q    <= '0;
      pulse_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      pw_q     <= pw_d;
      pri_q    <= pri_d;
      pulse_q  <= pulse_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pulse_out  = pulse_q;
  assign pri_strobe = strobe_q;
  assign pw_out     = pw_q;
  assign pri_out    = pri_q;
  assign entry_idx  = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pulse_sched.sv
// Directed self-checking bench for pulse_sched (default parameters).
module tb_pulse_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [3:0] cfg_pw;
  logic [7:0] cfg_pri;
  logic [3:0] cfg_rep;
  logic [3:0] num_entries;
  logic       loop_en;
  logic       start;
  logic       abort;
  logic       pulse_out;
  logic       pri_strobe;
  logic [3:0] pw_out;
  logic [7:0] pri_out;
  logic [2:0] entry_idx;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  pulse_sched dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pw(cfg_pw), .cfg_pri(cfg_pri), .cfg_rep(cfg_rep),
    .num_entries(num_entries), .loop_en(loop_en), .start(start), .abort(abort),
    .pulse_out(pulse_out), .pri_strobe(pri_strobe), .pw_out(pw_out), .pri_out(pri_out),
    .entry_idx(entry_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int pw, input int pri, input int rep);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_pw = 4'(pw); cfg_pri = 8'(pri); cfg_rep = 4'(rep);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Request a dwell; returns positioned in the first cycle after the sampling edge.
  task automatic go(input int n, input logic lp);
    @(negedge clk);
    num_entries = 4'(n); loop_en = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observe up to max_c busy cycles, counting pulses and PRI strobes.
  task automatic run(input int max_c, output int cyc, output int pulses, output int strobes,
                     output int idx5, output int idx6);
    cyc = 0; pulses = 0; strobes = 0; idx5 = -1; idx6 = -1;
    while (cyc < max_c && busy === 1'b1) begin
      cyc++;
      if (pulse_out === 1'b1)  pulses++;
      if (pri_strobe === 1'b1) strobes++;
      if (cyc == 5) idx5 = int'(entry_idx);
      if (cyc == 6) idx6 = int'(entry_idx);
      @(negedge clk);
    end
  endtask

  int cyc, pul, stb, i5, i6;
  int done_seen;

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_pw = '0; cfg_pri = '0; cfg_rep = '0;
    num_entries = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulse", 32'(pulse_out), 0);
    chk("rst_pw", 32'(pw_out), 0);
    chk("rst_pri", 32'(pri_out), 0);
    rst_n = 1'b1;

    // Single entry, two repeats of a 10-clock PRI.
    wr(0, 3, 9, 1);
    go(1, 1'b0);
    chk("t1_strobe0", 32'(pri_strobe), 1);
    chk("t1_pulse0", 32'(pulse_out), 1);
    run(100, cyc, pul, stb, i5, i6);
    chk("t1_cycles", 32'(cyc), 20);
    chk("t1_pulses", 32'(pul), 6);
    chk("t1_strobes", 32'(stb), 2);
    chk("t1_done", 32'(done), 1);
    @(negedge clk);
    chk("t1_done_off", 32'(done), 0);
    chk("t1_idle", 32'(busy), 0);

    // Two entries, one pass.
    wr(0, 2, 4, 0);
    wr(1, 5, 7, 2);
    go(2, 1'b0);
    run(100, cyc, pul, stb, i5, i6);
    chk("t2_cycles", 32'(cyc), 29);
    chk("t2_pulses", 32'(pul), 17);
    chk("t2_strobes", 32'(stb), 4);
    chk("t2_idx5", 32'(i5), 0);
    chk("t2_idx6", 32'(i6), 1);
    chk("t2_done", 32'(done), 1);
    @(negedge clk);

    // num_entries above DEPTH clamps to 8; entries 2..7 are still zero (1-clock PRIs).
    go(15, 1'b0);
    run(100, cyc, pul, stb, i5, i6);
    chk("clamp_cycles", 32'(cyc), 35);
    chk("clamp_strobes", 32'(stb), 10);
    chk("clamp_pulses", 32'(pul), 17);
    @(negedge clk);

    // Looping: wraps to entry 0 with no gap, then abort.
    go(2, 1'b1);
    run(29, cyc, pul, stb, i5, i6);
    chk("t3_cycles", 32'(cyc), 29);
    chk("t3_wrap_idx", 32'(entry_idx), 0);
    chk("t3_wrap_strobe", 32'(pri_strobe), 1);
    chk("t3_wrap_busy", 32'(busy), 1);
    chk("t3_wrap_pw", 32'(pw_out), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_abort_busy", 32'(busy), 0);
    chk("t3_abort_done", 32'(done), 0);

    // Abort at cnt=2 of the first period.
    wr(0, 3, 9, 1);
    go(1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_pulse_cnt2", 32'(pulse_out), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_pulse", 32'(pulse_out), 0);
    chk("t4_busy", 32'(busy), 0);
    done_seen = 0;
    repeat (6) begin
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    chk("t4_no_done", 32'(done_seen), 0);

    // Table write during RUN is ignored.
    go(1, 1'b0);
    cfg_we = 1'b1; cfg_addr = '0; cfg_pw = 4'd1; cfg_pri = 8'd2; cfg_rep = '0;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("t5_pw", 32'(pw_out), 3);
    chk("t5_pri", 32'(pri_out), 9);
    run(100, cyc, pul, stb, i5, i6);
    chk("t5_cycles", 32'(cyc), 19);
    chk("t5_pulses", 32'(pul), 5);
    @(negedge clk);

    // pw=0: strobe only.
    wr(0, 0, 3, 0);
    go(1, 1'b0);
    run(100, cyc, pul, stb, i5, i6);
    chk("t6_cycles", 32'(cyc), 4);
    chk("t6_pulses", 32'(pul), 0);
    chk("t6_strobes", 32'(stb), 1);
    @(negedge clk);

    // pw > pri: pulse covers the whole period.
    wr(0, 6, 3, 0);
    go(1, 1'b0);
    run(100, cyc, pul, stb, i5, i6);
    chk("t7_cycles", 32'(cyc), 4);
    chk("t7_pulses", 32'(pul), 4);
    @(negedge clk);

    // num_entries=0 ignores start.
    go(0, 1'b0);
    chk("t8_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t8_busy2", 32'(busy), 0);

    // Asynchronous reset mid-RUN clears outputs and the table.
    go(1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t9_busy", 32'(busy), 0);
    chk("t9_pulse", 32'(pulse_out), 0);
    chk("t9_strobe", 32'(pri_strobe), 0);
    chk("t9_pw", 32'(pw_out), 0);
    chk("t9_pri", 32'(pri_out), 0);
    chk("t9_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    go(1, 1'b0);
    run(100, cyc, pul, stb, i5, i6);
    chk("t9_tab_cycles", 32'(cyc), 1);
    chk("t9_tab_pulses", 32'(pul), 0);
    chk("t9_tab_strobes", 32'(stb), 1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
